uart_tx_engine: RTL and testbench

- Serial UART transmitter (8N1, LSB first) sitting directly downstream of the clock/reset generator.
- Runs on the generated design clock `clk` and negative reset `resetn`.
- Consumes bytes from the core/SOC over a valid/ready handshake and drives the board TX pin.
- A one-entry holding buffer lets consecutive frames go out with no idle gap between them.

---
 rtl/uart_tx_if.sv | 19 +
 rtl/uart_tx_engine.sv | 122 ++++++++++++
 tb/tb_uart_tx_engine.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
// Ports: tx_data/tx_valid from producer, tx_ready back from transmitter.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 LSB-first UART transmitter with a one-entry holding buffer.
// Ports: clk, resetn (async low), bus (slave handshake), tx line, busy.
module uart_tx_engine #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic     clk,
  input  logic     resetn,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t     state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] hold, hold_n;
  logic       hold_full, hold_full_n;
  logic       ready, tx_n;
  logic       last, accept, drain;

  assign last   = (cnt == LAST);
  assign accept = bus.tx_valid && !hold_full;
  // STOP-with-last drain is what makes frames back-to-back
  assign drain  = hold_full &&
                  (state == IDLE || (state == STOP && last));

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    shift_n     = shift;
    hold_n      = hold;
    hold_full_n = hold_full;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
      end
      START: begin
        if (last) begin
          state_n = DATA;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_n   = '0;
          shift_n = {1'b0, shift[7:1]};
          if (idx == 3'd7) begin
            state_n = STOP;
          end else begin
            idx_n = idx + 1'b1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (last) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (drain) begin
      state_n     = START;
      cnt_n       = '0;
      shift_n     = hold;
      hold_full_n = 1'b0;
    end
    if (accept) begin
      hold_n      = bus.tx_data;
      hold_full_n = 1'b1;
    end
    // line level follows the state being entered, so tx is a clean flop
    unique case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ready     <= 1'b1;
      tx        <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shift     <= shift_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      ready     <= !hold_full_n;
      tx        <= tx_n;
    end
  end

  assign bus.tx_ready = ready;
  assign busy = (state != IDLE) || hold_full;
endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine: frame tables, back-to-back,
// reset abort and random traffic checked by a line receiver.
module tb_uart_tx_engine;
  localparam int CPB = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic tx, busy;
  int   total = 0;
  int   passed = 0;
  int   rx_frames = 0;
  logic [7:0] exp_q[$];

  uart_tx_if bus();

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .tx(tx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [9:0] f;
  } vec_t;

  vec_t vecs[4];

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] req);
    total++;
    if (act !== req)
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, req, $time);
    else
      passed++;
  endfunction

  // line receiver: samples mid-bit, compares to expected bytes
  initial begin
    bit on = 0;
    int cnt = 0;
    logic [7:0] b = '0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        on = 0;
      end else if (!on) begin
        if (tx == 1'b0) begin
          on = 1;
          cnt = 0;
        end
      end else begin
        cnt++;
        if (cnt % CPB == CPB / 2) begin
          if (cnt / CPB == 0) begin
            chk("rx_start", 32'(tx), 32'd0);
          end else if (cnt / CPB <= 8) begin
            b[cnt / CPB - 1] = tx;
          end else begin
            chk("rx_stop", 32'(tx), 32'd1);
            if (exp_q.size() == 0)
              chk("rx_unexpected", 32'(b), 32'hFFFF_FFFF);
            else
              chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
            rx_frames++;
            on = 0;
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] d,
                            input logic [9:0] f);
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    exp_q.push_back(d);
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("ready_held", 32'(bus.tx_ready), 32'd0);
    chk("tx_before_start", 32'(tx), 32'd1);
    for (int k = 0; k < 10 * CPB; k++) begin
      @(negedge clk);
      chk("frame_bit", 32'(tx), 32'(f[k / CPB]));
      chk("busy_frame", 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("tx_after", 32'(tx), 32'd1);
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < bound), 32'd1);
  endtask

  initial begin
    logic [9:0] f1, f2;
    int fr0, n;
    vecs[0] = '{d: 8'h55, f: 10'h2AA};
    vecs[1] = '{d: 8'h00, f: 10'h200};
    vecs[2] = '{d: 8'hFF, f: 10'h3FE};
    vecs[3] = '{d: 8'hA5, f: 10'h34A};
    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;

    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_ready", 32'(bus.tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", 32'(tx), 32'd1);
      chk("idle_ready", 32'(bus.tx_ready), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    for (int i = 0; i < 4; i++)
      send_frame(vecs[i].d, vecs[i].f);

    // back-to-back A5 then 3C
    f1 = 10'h34A;
    f2 = 10'h278;
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.tx_data = 8'h3C;
    chk("b2b_ready0", 32'(bus.tx_ready), 32'd0);
    for (int k = 0; k < 20 * CPB; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("b2b_ready_first", 32'(bus.tx_ready), 32'd1);
        exp_q.push_back(8'h3C);
      end else begin
        if (k == 1) bus.tx_valid = 1'b0;
        chk("b2b_ready", 32'(bus.tx_ready),
            32'(k >= 10 * CPB));
      end
      if (k < 10 * CPB)
        chk("b2b_bit", 32'(tx), 32'(f1[k / CPB]));
      else
        chk("b2b_bit", 32'(tx), 32'(f2[(k - 10 * CPB) / CPB]));
    end
    @(negedge clk);
    chk("b2b_busy_end", 32'(busy), 32'd0);

    // 0xFF held on tx_valid across ready=0 windows
    fr0 = rx_frames;
    n = 0;
    @(negedge clk);
    bus.tx_data = 8'hFF;
    for (int c = 0; c < 100; c++) begin
      bus.tx_valid = 1'b1;
      if (bus.tx_ready) begin
        exp_q.push_back(8'hFF);
        n++;
      end
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    wait_idle(2000);
    chk("ff_frames", 32'(rx_frames - fr0), 32'(n));

    // reset during DATA with a byte held
    @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h00;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    bus.tx_valid = 1'b1;
    bus.tx_data  = 8'h77;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_ready", 32'(bus.tx_ready), 32'd0);
    #2 resetn = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_ready", 32'(bus.tx_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    fr0 = rx_frames;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("post_rst_tx", 32'(tx), 32'd1);
      chk("post_rst_busy", 32'(busy), 32'd0);
    end
    chk("no_residual", 32'(rx_frames - fr0), 32'd0);

    // random traffic checked by the receiver
    fr0 = rx_frames;
    for (int i = 0; i < 24; i++) begin
      int w = 0;
      @(negedge clk);
      bus.tx_valid = 1'b1;
      bus.tx_data  = 8'($urandom);
      while (!bus.tx_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      chk("rand_ready_timeout", 32'(w < 200), 32'd1);
      exp_q.push_back(bus.tx_data);
      @(negedge clk);
      bus.tx_valid = 1'b0;
      bus.tx_data  = 8'($urandom);
      repeat ($urandom_range(0, 3 * 10 * CPB / 2)) @(negedge clk);
    end
    wait_idle(5000);
    chk("rand_frames", 32'(rx_frames - fr0), 32'd24);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
